// File: rtl/loader_pkg.sv
// Shared types and constants for the IRAM boot loader.
package loader_pkg;

   // Frame parser states.
   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      ERR
   } state_t;

   // Default start-of-frame byte.
   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

   // Frame layout: MAGIC + LEN_LO + LEN_HI, then 4 bytes per word, then CSUM.
   localparam int HDR_BYTES  = 3;
   localparam int WORD_BYTES = 4;

   // Largest legal word count for a given IRAM address width (2**addr_w).
   function automatic logic [16:0] max_words(input int addr_w);
      return 17'(1) << addr_w;
   endfunction

endpackage

// File: rtl/ldr_word_pack.sv
// Packs four little-endian bytes into one 32-bit word.
module ldr_word_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx;
   logic [23:0] shreg;

   // The incoming byte completes a word when three bytes are already held.
   assign last_byte = (idx == 2'd3);

   // Byte index and shift register; pulse word_valid the cycle after the 4th byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: synchronous reset clears the data path too, so iram_wdata reads 0 out of reset.
         idx        <= '0;
         shreg      <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else if (clear) begin
         idx        <= '0;
         shreg      <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (byte_valid) begin
            shreg <= {byte_data, shreg[23:8]};
            idx   <= idx + 2'd1;
            if (last_byte) begin
               word       <= {byte_data, shreg};
               word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iram_loader.sv
// Byte-stream boot loader: parses a checksummed frame, writes IRAM, then releases the core.
module iram_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W  = 14,
   parameter int         TIMEOUT = 100000,
   parameter logic [7:0] MAGIC   = MAGIC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              iram_we,
   output logic [ADDR_W-1:0] iram_addr,
   output logic [31:0]       iram_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_written
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [16:0]     MAX_N    = max_words(ADDR_W);

   state_t        state, next_state;
   logic          accept, in_frame, tmo_hit;
   logic          frame_start, frame_pass, frame_fail, data_byte;
   logic          release_pending;
   logic [7:0]    len_lo, csum;
   logic [15:0]   len_rx, n_words, rx_word;
   logic [TW-1:0] tmo_cnt;
   logic          last_byte, word_valid;
   logic [31:0]   word;

   // The loader never applies backpressure.
   assign rx_ready = 1'b1;
   assign accept   = rx_valid;
   assign len_rx   = {rx_data, len_lo};
   assign in_frame = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
   assign tmo_hit  = in_frame && !accept && (tmo_cnt == TMO_LAST);

   ldr_word_pack u_pack (
      .clk        (clk),
      .rst        (rst),
      .clear      (frame_start),
      .byte_valid (data_byte),
      .byte_data  (rx_data),
      .last_byte  (last_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   assign iram_we    = word_valid;
   assign iram_addr  = words_written[ADDR_W-1:0];
   assign iram_wdata = word;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state decode; an idle timeout overrides everything inside a frame.
   always_comb begin
      // NOTE: default first so no path leaves next_state unassigned (no latch).
      next_state = state;
      if (tmo_hit) begin
         next_state = ERR;
      end else begin
         case (state)
            IDLE: if (accept && rx_data == MAGIC) next_state = LEN0;
            LEN0: if (accept) next_state = LEN1;
            LEN1: if (accept) begin
               if ({1'b0, len_rx} > MAX_N) next_state = ERR;
               else if (len_rx == 16'd0)   next_state = CSUM;
               else                        next_state = DATA;
            end
            DATA: if (accept && last_byte && (rx_word + 16'd1 == n_words)) next_state = CSUM;
            CSUM: if (accept) next_state = (rx_data == csum) ? IDLE : ERR;
            ERR:  next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Frame-level event strobes derived from the current state and handshake.
   always_comb begin
      frame_start = (state == IDLE) && accept && (rx_data == MAGIC);
      frame_pass  = (state == CSUM) && accept && (rx_data == csum);
      frame_fail  = (next_state == ERR) && (state != ERR);
      data_byte   = (state == DATA) && accept;
   end

   // Length capture, word counter, checksum accumulator and idle timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_lo  <= '0;
         n_words <= '0;
         rx_word <= '0;
         csum    <= '0;
         tmo_cnt <= '0;
      end else if (frame_start) begin
         rx_word <= '0;
         csum    <= '0;
         tmo_cnt <= '0;
      end else begin
         if (in_frame) tmo_cnt <= accept ? '0 : tmo_cnt + TW'(1);
         if (state == LEN0 && accept) len_lo  <= rx_data;
         if (state == LEN1 && accept) n_words <= len_rx;
         if (data_byte) begin
            csum <= csum + rx_data;
            if (last_byte) rx_word <= rx_word + 16'd1;
         end
      end
   end

   // Status flags, core reset release (one cycle after load_done) and write count.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_done       <= 1'b0;
         load_err        <= 1'b0;
         busy            <= 1'b0;
         core_rst_n      <= 1'b0;
         release_pending <= 1'b0;
         words_written   <= '0;
      end else begin
         release_pending <= frame_pass;
         if (frame_start) begin
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            busy          <= 1'b1;
            core_rst_n    <= 1'b0;
            words_written <= '0;
         end else begin
            if (frame_pass) begin
               load_done <= 1'b1;
               busy      <= 1'b0;
            end
            if (frame_fail) begin
               load_err <= 1'b1;
               busy     <= 1'b0;
            end
            if (release_pending) core_rst_n <= 1'b1;
            if (word_valid) words_written <= words_written + (ADDR_W + 1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_iram_loader.sv
// Randomized scoreboard bench for iram_loader: expected IRAM writes are queued
// from a frame-level model and popped by an independent write monitor.
module tb_iram_loader;

   localparam int         ADDR_W  = 4;
   localparam int         TIMEOUT = 50;
   localparam logic [7:0] MAGIC   = 8'hA5;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              iram_we;
   logic [ADDR_W-1:0] iram_addr;
   logic [31:0]       iram_wdata;
   logic              core_rst_n;
   logic              busy;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_written;

   int  total = 0;
   int  bad   = 0;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   iram_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT),
      .MAGIC   (MAGIC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .iram_we       (iram_we),
      .iram_addr     (iram_addr),
      .iram_wdata    (iram_wdata),
      .core_rst_n    (core_rst_n),
      .busy          (busy),
      .load_done     (load_done),
      .load_err      (load_err),
      .words_written (words_written)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: every IRAM strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t w;
      if (iram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", 32'(iram_addr), 32'hFFFF_FFFF);
         end else begin
            w = exp_q.pop_front();
            check("we_addr", 32'(iram_addr), w.addr);
            check("we_data", iram_wdata, w.data);
         end
      end
   end

   // Present one byte for one cycle after 'gap' idle cycles; returns 1ns after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_garbage(input int count);
      logic [7:0] g;
      for (int i = 0; i < count; i++) begin
         g = 8'($urandom_range(0, 255));
         if (g == MAGIC) g = 8'h5A;
         send_byte(g, $urandom_range(0, 2));
      end
   endtask

   function automatic byte_q_t make_frame(input int n, input logic [7:0] csum_xor);
      byte_q_t    q;
      logic [7:0] s;
      logic [7:0] b;
      s = 8'h00;
      q.push_back(MAGIC);
      q.push_back(n[7:0]);
      q.push_back(n[15:8]);
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom_range(0, 255));
         q.push_back(b);
         s = s + b;
      end
      q.push_back(s ^ csum_xor);
      return q;
   endfunction

   // Frame-level reference: decide outcome from the byte list, queue expected writes, drive, then check.
   task automatic run_frame(input string tag, input byte_q_t fr, input int max_gap,
                            input int stall_idx, input int stall_gap);
      int         n, avail, nw, sum, gap;
      bit         too_long, complete, exp_ok;
      wr_t        w;
      n        = int'(fr[1]) + 256 * int'(fr[2]);
      too_long = (n > (1 << ADDR_W));
      exp_ok   = 1'b0;
      nw       = 0;
      complete = too_long;
      if (!too_long) begin
         avail = fr.size() - 3;
         if (avail > 4 * n) avail = 4 * n;
         nw = avail / 4;
         for (int i = 0; i < nw; i++) begin
            w.addr = i;
            w.data = 0;
            for (int k = 0; k < 4; k++) w.data = w.data + (int'(fr[3 + 4 * i + k]) << (8 * k));
            exp_q.push_back(w);
         end
         if (fr.size() >= 4 + 4 * n) begin
            complete = 1'b1;
            sum = 0;
            for (int j = 0; j < 4 * n; j++) sum = sum + int'(fr[3 + j]);
            exp_ok = (int'(fr[3 + 4 * n]) == (sum % 256));
         end
      end

      for (int i = 0; i < fr.size(); i++) begin
         gap = (i == 0) ? 0 : $urandom_range(0, max_gap);
         if (i == stall_idx) gap = stall_gap;
         send_byte(fr[i], gap);
         if (i == 0) begin
            check({tag, "_start_hold"}, core_rst_n, 1'b0);
            check({tag, "_start_busy"}, busy, 1'b1);
            check({tag, "_start_done"}, load_done, 1'b0);
            check({tag, "_start_err"}, load_err, 1'b0);
         end
      end

      if (complete) begin
         check({tag, "_edge_done"}, load_done, exp_ok);
         check({tag, "_edge_err"}, load_err, !exp_ok);
         check({tag, "_edge_gap"}, core_rst_n, 1'b0);
         repeat (4) begin
            @(posedge clk); #1;
         end
      end else begin
         repeat (TIMEOUT + 5) begin
            @(posedge clk); #1;
         end
      end

      check({tag, "_done"}, load_done, exp_ok);
      check({tag, "_err"}, load_err, !exp_ok);
      check({tag, "_core"}, core_rst_n, exp_ok);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_words"}, 32'(words_written), nw);
      check({tag, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, rx_ready, 1'b1);
      check({tag, "_we"}, iram_we, 1'b0);
      check({tag, "_addr"}, 32'(iram_addr), 0);
      check({tag, "_wdata"}, iram_wdata, 0);
      check({tag, "_core"}, core_rst_n, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, load_done, 1'b0);
      check({tag, "_err"}, load_err, 1'b0);
      check({tag, "_words"}, 32'(words_written), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      byte_q_t t1, fr;
      int      n;
      logic [7:0] x;

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // T1: two-word frame with correct checksum.
      t1 = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
      run_frame("t1", t1, 2, -1, 0);

      // T2: same frame, bad checksum; words still written.
      fr = t1;
      fr[11] = 8'h65;
      run_frame("t2", fr, 2, -1, 0);

      // T3: garbage ignored in IDLE, then an empty frame.
      send_byte(8'h00, 0);
      send_byte(8'hFF, 1);
      send_byte(8'h5A, 0);
      check("t3_garbage_busy", busy, 1'b0);
      run_frame("t3", '{8'hA5, 8'h00, 8'h00, 8'h00}, 1, -1, 0);

      // T4: stall mid-frame until timeout; then a byte exactly in the expiry cycle.
      run_frame("t4_tmo", '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22}, 1, -1, 0);
      run_frame("t4_edge", '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA}, 1, 5, TIMEOUT - 1);

      // T5: length limit (2**ADDR_W = 16 words allowed, 17 rejected).
      run_frame("t5_over", '{8'hA5, 8'h11, 8'h00}, 1, -1, 0);
      run_frame("t5_big", '{8'hA5, 8'h01, 8'h40}, 1, -1, 0);
      run_frame("t5_max", make_frame(16, 8'h00), 1, -1, 0);

      // T6: reset in the middle of the data phase.
      fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      exp_q.push_back('{addr: 0, data: 32'h4433_2211});
      for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_values("t6_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("t6_pending", exp_q.size(), 0);
      check("t6_words", 32'(words_written), 0);
      run_frame("t6_after", t1, 2, -1, 0);

      // Random frames: varying length, gaps, corrupted checksums, truncation and leading garbage.
      for (int r = 0; r < 20; r++) begin
         send_garbage($urandom_range(0, 2));
         n = $urandom_range(0, 6);
         x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         fr = make_frame(n, x);
         if ($urandom_range(0, 9) == 0) begin
            while (fr.size() > 3 + $urandom_range(0, 4 * n)) void'(fr.pop_back());
         end
         run_frame("rnd", fr, 3, -1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
